uc_secuenciador: RTL and testbench
==================================

// Module: uc_secuenciador
// PURPOSE
//  Multi-cycle control sequencer: owns the 4-bit control-unit state register and
//  decodes it into datapath control strobes. Runs fetch/decode/execute for a
//  2-bit opcode, with a req/ack memory handshake and a wait timeout. Sits
//  between the top-level start/op inputs and the datapath (PC, IR, ALU, reg file).
// PARAMETERS
//  WAIT_MAX  15  cycles mem_ack may stay low in WAIT_F/WAIT_M before ERR (1..15)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  synchronous reset, active low
//  start      in   1  begin one instruction cycle (level, sampled in IDLE)
//  op         in   2  opcode: 00 ALU, 01 LOAD, 10 BRANCH, 11 HALT (sampled in DECODE)
//  zero       in   1  ALU zero flag (sampled in BRANCH)
//  mem_ack    in   1  memory acknowledge
//  mem_req    out  1  memory request
//  ir_load    out  1  latch instruction register
//  pc_inc     out  1  PC <= PC+1
//  pc_load    out  1  PC <= branch target
//  alu_en     out  1  ALU operate
//  reg_we     out  1  register-file write
//  busy       out  1  sequencer not in IDLE/DONE/ERR
//  done       out  1  instruction complete
//  error      out  1  memory timeout, sticky
//  state      out  4  current state code (debug)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE(0), wait counter=0; all outputs 0.
//    Reset is honoured in every state, mid-handshake included; mem_req drops next cycle.
//  - State codes: IDLE 0, FETCH 1, WAIT_F 2, DECODE 3, EXEC 4, MEM_RD 5, WAIT_M 6,
//    WB 7, BRANCH 8, DONE 9, ERR 10. Codes 11-15 are illegal -> IDLE next cycle.
//  - Transitions (one per posedge):
//    IDLE: start=1 -> FETCH, else hold.   FETCH -> WAIT_F.
//    WAIT_F: mem_ack=1 -> DECODE; cnt==WAIT_MAX-1 with ack=0 -> ERR; else hold.
//    DECODE: op 00/01 -> EXEC, 10 -> BRANCH, 11 -> DONE.
//    EXEC: op 01 -> MEM_RD, else -> WB.   MEM_RD -> WAIT_M.
//    WAIT_M: same rule as WAIT_F, success -> WB.   WB -> DONE.   BRANCH -> DONE.
//    DONE: start=0 -> IDLE, else hold (no re-trigger while start held).
//    ERR: hold until reset.
//  - op is sampled in DECODE and held in a 2-bit register for EXEC; later op
//    changes have no effect.
//  - Outputs (combinational from state register; Moore except ir_load/pc_load):
//    mem_req = FETCH|WAIT_F|MEM_RD|WAIT_M; ir_load = WAIT_F & mem_ack;
//    alu_en = EXEC; reg_we = WB; pc_inc = DECODE; pc_load = BRANCH & zero;
//    done = DONE; error = ERR; busy = not (IDLE|DONE|ERR).
//  - mem_ack is ignored outside WAIT_F/WAIT_M (ack in FETCH or MEM_RD does not
//    shorten the handshake).
//  - Wait counter: 4 bits, cleared on any entry to WAIT_F/WAIT_M and on ack;
//    +1 per cycle with ack=0. Never wraps: ERR is taken at WAIT_MAX-1.
//  - Latency, start to done with immediate ack: ALU 6 cycles, LOAD 8,
//    BRANCH 5, HALT 4.
// TESTING
//  T1 reset: rst_n=0 in WAIT_M with cnt=5 -> next cycle state=0, all outputs 0.
//  T2 ALU: start=1, op=00, mem_ack=1 in WAIT_F -> states 1,2,3,4,7,9; reg_we 1 cycle; done.
//  T3 LOAD: op=01, ack delayed 3 cycles in WAIT_M -> mem_req high 4 cycles there, then WB, DONE.
//  T4 BRANCH: op=10, zero=1 -> pc_load=1 for 1 cycle; repeat with zero=0 -> pc_load stays 0.
//  T5 timeout: WAIT_MAX=4, mem_ack=0 in WAIT_F -> ERR after 4 cycles; error=1; start ignored.
//  T6 start held in DONE: stays 9 until start=0, then IDLE; op changed in EXEC -> no effect.

Source files
------------

// File: rtl/uc_secuenciador.sv
// Multi-cycle control sequencer: fetch/decode/execute over a 2-bit opcode with a
// req/ack memory handshake, a bounded wait counter and a sticky timeout state.
module uc_secuenciador #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       alu_en,
  output logic       reg_we,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StWaitF  = 4'd2,
    StDecode = 4'd3,
    StExec   = 4'd4,
    StMemRd  = 4'd5,
    StWaitM  = 4'd6,
    StWb     = 4'd7,
    StBranch = 4'd8,
    StDone   = 4'd9,
    StErr    = 4'd10
  } state_e;

  localparam logic [3:0] CntLast = 4'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch: begin
        state_d = StWaitF;
        cnt_d   = '0;
      end
      StWaitF: begin
        if (mem_ack) begin
          state_d = StDecode;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDecode: begin
        op_d = op;
        case (op)
          2'b00, 2'b01: state_d = StExec;
          2'b10:        state_d = StBranch;
          default:      state_d = StDone;
        endcase
      end
      // Only the opcode latched in DECODE steers EXEC.
      StExec:   state_d = (op_q == 2'b01) ? StMemRd : StWb;
      StMemRd: begin
        state_d = StWaitM;
        cnt_d   = '0;
      end
      StWaitM: begin
        if (mem_ack) begin
          state_d = StWb;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWb:     state_d = StDone;
      StBranch: state_d = StDone;
      StDone:   if (!start) state_d = StIdle;
      StErr:    state_d = StErr;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req = (state_q == StFetch) || (state_q == StWaitF) ||
              (state_q == StMemRd) || (state_q == StWaitM);
    ir_load = (state_q == StWaitF) && mem_ack;
    pc_inc  = (state_q == StDecode);
    pc_load = (state_q == StBranch) && zero;
    alu_en  = (state_q == StExec);
    reg_we  = (state_q == StWb);
    done    = (state_q == StDone);
    error   = (state_q == StErr);
    busy    = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
    state   = state_q;
  end

endmodule

// File: tb/tb_uc_secuenciador.sv
// Bench for uc_secuenciador: builds the expected state trace of each instruction
// from the opcode and ack delays, then drives it cycle by cycle and checks.
module tb_uc_secuenciador;

  localparam int unsigned WMAX = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, zero, mem_ack;
  logic [1:0] op;
  logic       mem_req, ir_load, pc_inc, pc_load, alu_en, reg_we, busy, done, error;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  uc_secuenciador #(.WAIT_MAX(WMAX)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .zero    (zero),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .ir_load (ir_load),
    .pc_inc  (pc_inc),
    .pc_load (pc_load),
    .alu_en  (alu_en),
    .reg_we  (reg_we),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .state   (state)
  );

  always #5 clk = ~clk;

  // {mem_req, ir_load, pc_inc, pc_load, alu_en, reg_we, busy, done, error}
  function automatic logic [8:0] exp_outs(input int s, input logic a, input logic z);
    logic [8:0] o;
    o[8] = (s == 1) || (s == 2) || (s == 5) || (s == 6);
    o[7] = (s == 2) && a;
    o[6] = (s == 3);
    o[5] = (s == 8) && z;
    o[4] = (s == 4);
    o[3] = (s == 7);
    o[2] = !((s == 0) || (s == 9) || (s == 10));
    o[1] = (s == 9);
    o[0] = (s == 10);
    return o;
  endfunction

  task automatic cycle(input logic rn, input logic st, input logic a, input logic z,
                       input logic [1:0] o, input int s_exp, input string tag);
    logic [8:0] got, exp;
    @(negedge clk);
    rst_n   = rn;
    start   = st;
    mem_ack = a;
    zero    = z;
    op      = o;
    #1;
    got = {mem_req, ir_load, pc_inc, pc_load, alu_en, reg_we, busy, done, error};
    exp = exp_outs(s_exp, a, z);
    checks++;
    assert (state === 4'(s_exp)) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, s_exp);
    end
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s outputs (state %0d): got %b expected %b", tag, s_exp, got, exp);
    end
  endtask

  // fd/md: cycles of ack=0 before ack in WAIT_F/WAIT_M (>= WMAX means timeout).
  // abort_at: trace index whose cycle has rst_n=0 (-1 for none).
  task automatic run(input logic [1:0] opc, input int fd, input int md, input int hold,
                     input int abort_at, input logic zb, input string tag);
    int   st[$];
    logic ak[$];
    bit   err;
    int   ab;
    logic s_in, z_in;
    logic [1:0] o_in;
    err = 0;
    ab  = abort_at;
    st.push_back(1); ak.push_back(1'($urandom));
    for (int k = 0; k < int'(WMAX); k++) begin
      st.push_back(2); ak.push_back(k == fd);
      if (k == fd) break;
      if (k == int'(WMAX) - 1) err = 1;
    end
    if (!err) begin
      st.push_back(3); ak.push_back(1'($urandom));
      if (opc == 2'b00 || opc == 2'b01) begin
        st.push_back(4); ak.push_back(1'($urandom));
      end
      if (opc == 2'b01) begin
        st.push_back(5); ak.push_back(1'($urandom));
        for (int k = 0; k < int'(WMAX); k++) begin
          st.push_back(6); ak.push_back(k == md);
          if (k == md) break;
          if (k == int'(WMAX) - 1) err = 1;
        end
      end
      if (!err) begin
        if (opc == 2'b00 || opc == 2'b01) begin
          st.push_back(7); ak.push_back(1'($urandom));
        end
        if (opc == 2'b10) begin
          st.push_back(8); ak.push_back(1'($urandom));
        end
        for (int h = 0; h <= hold; h++) begin
          st.push_back(9); ak.push_back(1'($urandom));
        end
      end
    end
    if (err) begin
      repeat (3) begin
        st.push_back(10); ak.push_back(1'($urandom));
      end
      ab = st.size() - 1;
    end
    if (ab >= 0 && ab < st.size()) begin
      while (st.size() > ab + 1) begin
        void'(st.pop_back());
        void'(ak.pop_back());
      end
    end else begin
      ab = -1;
    end

    cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 0, {tag, "-idle"});
    cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 0, {tag, "-start"});
    for (int i = 0; i < st.size(); i++) begin
      if (st[i] == 9) s_in = (i + 1 < st.size()) && (st[i + 1] == 9);
      else            s_in = 1'($urandom);
      o_in = (st[i] == 3) ? opc : 2'($urandom);
      z_in = (st[i] == 8) ? zb : 1'($urandom);
      cycle((i == ab) ? 1'b0 : 1'b1, s_in, ak[i], z_in, o_in, st[i], tag);
    end
    cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 0, {tag, "-end"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    zero    = 1'b0;
    mem_ack = 1'b0;
    op      = 2'b00;
    @(posedge clk);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, "reset");

    run(2'b00, 0, 0, 0, -1, 1'b0, "alu");
    run(2'b01, 0, 3, 1, -1, 1'b0, "load_ackdly3");
    run(2'b10, 0, 0, 0, -1, 1'b1, "branch_z1");
    run(2'b10, 0, 0, 0, -1, 1'b0, "branch_z0");
    run(2'b11, 0, 0, 0, -1, 1'b0, "halt");
    run(2'b00, 4, 0, 0, -1, 1'b0, "timeout_f");
    run(2'b01, 1, 9, 0, -1, 1'b0, "timeout_m");
    run(2'b00, 3, 0, 0, -1, 1'b0, "ack_last_f");
    run(2'b01, 0, 3, 0, 7, 1'b0, "reset_waitm");
    run(2'b00, 0, 0, 3, -1, 1'b0, "done_hold");

    for (int r = 0; r < 40; r++) begin
      run(2'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 2)),
          ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1,
          1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
